adc_pulse_emulator: RTL and testbench

// Synthetic ADC sample source for the cusp-like shaping filter input. Emits one

---
 rtl/adc_pulse_emulator.sv | 107 ++++++++++
 tb/tb_adc_pulse_emulator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_pulse_emulator.sv
// Synthetic charge-preamp ADC source: baseline + programmable step + exponential decay, one sample per clk.
// Triggers (external or periodic) are registered once before they reach the accumulator, so a step shows one cycle after the trigger.
module adc_pulse_emulator #(
  parameter int SIZE_ADC_DATA = 12,
  parameter int FRAC          = 4,
  parameter int PERIOD_W      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     trigger,
  input  logic                     auto_mode,
  input  logic [PERIOD_W-1:0]      period,
  input  logic [SIZE_ADC_DATA-1:0] amplitude,
  input  logic [SIZE_ADC_DATA-1:0] baseline,
  input  logic [3:0]               decay_shift,
  output logic [SIZE_ADC_DATA-1:0] adc_data,
  output logic                     data_valid,
  output logic                     pulse_start,
  output logic                     busy,
  output logic [15:0]              pileup_cnt
);

  localparam int AW = SIZE_ADC_DATA + FRAC;

  typedef enum logic [1:0] {OFF, WAIT, PULSE} state_t;

  state_t              state;
  logic [AW-1:0]       acc;
  logic [PERIOD_W-1:0] cnt;
  logic                evt_q;

  logic                auto_tick;
  logic                trig_evt;
  logic [PERIOD_W-1:0] cnt_next;
  logic [AW-1:0]       decay;
  logic [AW-1:0]       step;
  logic [AW:0]         sum;
  logic [AW-1:0]       acc_next;
  logic [SIZE_ADC_DATA:0]   out_sum;
  logic [SIZE_ADC_DATA-1:0] out_sat;

  always_comb begin
    auto_tick = auto_mode && (period != '0) && (cnt == period - 1'b1);
    trig_evt  = trigger | auto_tick;

    // Wrap on >= so a period shortened below the running count still wraps.
    if ((period == '0) || (cnt >= period - 1'b1))
      cnt_next = '0;
    else
      cnt_next = cnt + 1'b1;

    decay = (decay_shift == 4'd0) ? '0 : (acc >> decay_shift);
    step  = evt_q ? {amplitude, {FRAC{1'b0}}} : '0;
    sum   = {1'b0, acc} - {1'b0, decay} + {1'b0, step};

    if (sum[AW])
      acc_next = '1;
    else if ((decay_shift != 4'd0) && (decay == '0) && !evt_q)
      acc_next = '0;  // residue too small to decay further: terminate the tail
    else
      acc_next = sum[AW-1:0];

    out_sum = {1'b0, baseline} + {1'b0, acc_next[AW-1:FRAC]};
    out_sat = out_sum[SIZE_ADC_DATA] ? '1 : out_sum[SIZE_ADC_DATA-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= OFF;
      acc         <= '0;
      cnt         <= '0;
      evt_q       <= 1'b0;
      adc_data    <= '0;
      data_valid  <= 1'b0;
      pulse_start <= 1'b0;
      busy        <= 1'b0;
      pileup_cnt  <= '0;
    end else if (!enable) begin
      state       <= OFF;
      acc         <= '0;
      cnt         <= '0;
      evt_q       <= 1'b0;
      adc_data    <= baseline;
      data_valid  <= 1'b0;
      pulse_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      evt_q       <= trig_evt;
      acc         <= acc_next;
      adc_data    <= out_sat;
      data_valid  <= 1'b1;
      pulse_start <= evt_q;
      busy        <= (acc_next != '0);
      if (evt_q && (acc != '0) && (pileup_cnt != 16'hFFFF))
        pileup_cnt <= pileup_cnt + 16'd1;
      case (state)
        OFF:     state <= WAIT;
        WAIT:    if (evt_q) state <= PULSE;
        PULSE:   if (acc_next == '0) state <= WAIT;
        default: state <= OFF;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_pulse_emulator.sv
// Directed bench for adc_pulse_emulator: hand-computed sample sequences checked with immediate assertions.
module tb_adc_pulse_emulator;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        trigger;
  logic        auto_mode;
  logic [15:0] period;
  logic [11:0] amplitude;
  logic [11:0] baseline;
  logic [3:0]  decay_shift;
  logic [11:0] adc_data;
  logic        data_valid;
  logic        pulse_start;
  logic        busy;
  logic [15:0] pileup_cnt;

  int n_cmp = 0;
  int n_err = 0;

  adc_pulse_emulator dut (
    .clk(clk), .reset(reset), .enable(enable), .trigger(trigger),
    .auto_mode(auto_mode), .period(period), .amplitude(amplitude),
    .baseline(baseline), .decay_shift(decay_shift), .adc_data(adc_data),
    .data_valid(data_valid), .pulse_start(pulse_start), .busy(busy),
    .pileup_cnt(pileup_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  logic [11:0] t1_seq [4] = '{12'd150, 12'd125, 12'd106, 12'd92};
  logic        t3_trg [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [11:0] t3_adc [6] = '{12'd50, 12'd150, 12'd125, 12'd106, 12'd192, 12'd156};
  logic        t3_ps  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    int ps_seen;
    int waited;

    reset = 1'b0; enable = 1'b0; trigger = 1'b0; auto_mode = 1'b0;
    period = 16'd0; amplitude = 12'd100; baseline = 12'd50; decay_shift = 4'd2;
    #12;
    chk("rst_adc", adc_data, 0);
    chk("rst_valid", data_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ps", pulse_start, 0);
    chk("rst_pileup", pileup_cnt, 0);

    // Test 1: single pulse
    reset = 1'b1;
    tick();
    chk("off_adc", adc_data, 50);
    chk("off_valid", data_valid, 0);
    enable = 1'b1;
    tick();
    chk("wait_valid", data_valid, 1);
    chk("wait_adc", adc_data, 50);
    chk("wait_busy", busy, 0);
    pulse_trigger();
    chk("t1_lat_adc", adc_data, 50);
    chk("t1_lat_ps", pulse_start, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_adc", adc_data, t1_seq[i]);
      chk("t1_ps", pulse_start, (i == 0) ? 1 : 0);
      chk("t1_busy", busy, 1);
    end
    ps_seen = 0;
    waited = 0;
    while (busy && waited < 60) begin
      tick();
      waited++;
      if (pulse_start) ps_seen++;
    end
    chk("t1_tail_ends", busy, 0);
    chk("t1_tail_adc", adc_data, 50);
    chk("t1_tail_ps", ps_seen, 0);

    // Test 2: periodic trigger, amplitude 0 keeps the accumulator empty
    amplitude = 12'd0; auto_mode = 1'b1; period = 16'd10;
    waited = 0;
    while (!pulse_start && waited < 30) begin
      tick();
      waited++;
    end
    chk("t2_first_tick", pulse_start, 1);
    for (int i = 1; i <= 40; i++) begin
      tick();
      chk("t2_period", pulse_start, (i % 10 == 0) ? 1 : 0);
    end
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("t2_gap", pulse_start, 0);
    end
    trigger = 1'b1; amplitude = 12'd100; decay_shift = 4'd0;
    tick();
    trigger = 1'b0; auto_mode = 1'b0;
    tick();
    chk("t2_coinc_ps", pulse_start, 1);
    chk("t2_coinc_adc", adc_data, 150);
    tick();
    chk("t2_coinc_hold", adc_data, 150);
    chk("t2_coinc_ps_off", pulse_start, 0);
    auto_mode = 1'b1; period = 16'd0;
    ps_seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (pulse_start) ps_seen++;
    end
    chk("t2_period0", ps_seen, 0);
    chk("t2_pileup", pileup_cnt, 0);
    auto_mode = 1'b0;

    // Test 3: pile-up
    enable = 1'b0;
    tick();
    enable = 1'b1; decay_shift = 4'd2; amplitude = 12'd100; baseline = 12'd50;
    tick();
    for (int i = 0; i < 6; i++) begin
      trigger = t3_trg[i];
      tick();
      trigger = 1'b0;
      chk("t3_adc", adc_data, t3_adc[i]);
      chk("t3_ps", pulse_start, t3_ps[i]);
    end
    chk("t3_pileup", pileup_cnt, 1);

    // Test 4: saturation
    enable = 1'b0;
    tick();
    enable = 1'b1; baseline = 12'd100; amplitude = 12'd4095; decay_shift = 4'd0;
    tick();
    pulse_trigger();
    tick();
    chk("t4_sat_adc", adc_data, 4095);
    chk("t4_sat_busy", busy, 1);
    pulse_trigger();
    pulse_trigger();
    tick();
    chk("t4_stack_adc", adc_data, 4095);
    amplitude = 12'd1;
    pulse_trigger();
    tick();
    tick();
    chk("t4_no_wrap", adc_data, 4095);
    chk("t4_pileup", pileup_cnt, 4);

    // Test 5: enable drop mid-decay, then a clean pulse
    enable = 1'b0;
    tick();
    enable = 1'b1; baseline = 12'd50; amplitude = 12'd100; decay_shift = 4'd2;
    tick();
    pulse_trigger();
    tick();
    tick();
    chk("t5_mid", adc_data, 125);
    enable = 1'b0;
    tick();
    chk("t5_off_valid", data_valid, 0);
    chk("t5_off_adc", adc_data, 50);
    chk("t5_off_busy", busy, 0);
    enable = 1'b1;
    tick();
    chk("t5_reen_adc", adc_data, 50);
    pulse_trigger();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_adc", adc_data, t1_seq[i]);
    end

    // Test 6: asynchronous reset mid-pulse
    reset = 1'b0;
    #1;
    chk("t6_adc", adc_data, 0);
    chk("t6_valid", data_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ps", pulse_start, 0);
    chk("t6_pileup", pileup_cnt, 0);
    reset = 1'b1;
    tick();
    chk("t6_resume_adc", adc_data, 50);
    chk("t6_resume_valid", data_valid, 1);
    chk("t6_resume_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
